// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port request/response controller for a synchronous RAM with read timeout
// Ports: clk/clr (async active-low reset); request side reqValid/reqReady/reqWrite/reqAddr/reqData;
// response side respValid/respReady/respData/respError; RAM side ramWriteEnable/ramAddr/ramWriteData,
// ramReadEnable/ramReadAddr/ramReadData/ramDataReady.
// Optional build macro MEMCTRL_WRITE_PROTECT_EN rejects stores at or above PROT_BASE.
module mem_access_ctrl #(
  parameter int width     = 8,
  parameter int length    = 8,
  parameter int TIMEOUT   = 15,
  parameter int PROT_BASE = 240
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic [length-1:0] reqAddr,
  input  logic [width-1:0]  reqData,
  output logic              reqReady,
  output logic              respValid,
  input  logic              respReady,
  output logic [width-1:0]  respData,
  output logic              respError,
  output logic              ramWriteEnable,
  output logic              ramReadEnable,
  output logic [length-1:0] ramAddr,
  output logic [length-1:0] ramReadAddr,
  output logic [width-1:0]  ramWriteData,
  input  logic              ramDataReady,
  input  logic [width-1:0]  ramReadData
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, CAPT, RESP} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [length-1:0] addr_q, addr_d;
  logic [width-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d, re_q, re_d, valid_q, valid_d, err_q, err_d;
  logic hs, prot;
  assign reqReady       = state_q == IDLE;
  assign hs             = reqValid && reqReady;
  assign respValid      = valid_q;
  assign respData       = rdata_q;
  assign respError      = err_q;
  assign ramWriteEnable = we_q;
  assign ramReadEnable  = re_q;
  assign ramAddr        = addr_q;
  assign ramReadAddr    = addr_q;
  assign ramWriteData   = wdata_q;
`ifdef MEMCTRL_WRITE_PROTECT_EN
  localparam logic [length-1:0] PROT_A = PROT_BASE[length-1:0];
  assign prot = reqWrite && (reqAddr >= PROT_A);
`else
  assign prot = 1'b0;
`endif
  // Enables are computed from the next state so they are high exactly while in WRITE or READ/WAIT.
  // respValid rises one cycle after entering RESP, giving store latency 2 and load latency 4.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        addr_d  = reqAddr;
        wdata_d = reqData;
        state_d = prot ? RESP : (reqWrite ? WRITE : READ);
        we_d    = reqWrite && !prot;
        re_d    = !reqWrite;
        err_d   = prot;
        rdata_d = '0;
      end
      WRITE: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = '0;
        re_d    = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (ramDataReady) state_d = CAPT;
        else if (cnt_d == TMO) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else re_d = 1'b1;
      end
      CAPT: begin
        state_d = RESP;
        rdata_d = ramReadData;
        err_d   = 1'b0;
      end
      RESP: if (valid_q && respReady) begin
        state_d = IDLE;
        valid_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
      end else valid_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench with a transaction-level reference model
module tb_mem_access_ctrl;
  localparam int TMO = 15;
`ifdef MEMCTRL_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 0, clr = 0;
  logic reqValid = 0, reqWrite = 0, reqReady;
  logic [7:0] reqAddr = 0, reqData = 0;
  logic respValid, respReady = 0, respError;
  logic [7:0] respData;
  logic ramWriteEnable, ramReadEnable, ramDataReady = 0;
  logic [7:0] ramAddr, ramReadAddr, ramWriteData, ramReadData;
  logic [7:0] ram [256];
  bit written [256];
  logic [7:0] exp_mem [256];
  int n_chk = 0, n_pass = 0, excl = 0;
  mem_access_ctrl #(.width(8), .length(8), .TIMEOUT(TMO), .PROT_BASE(240)) dut (
    .clk(clk), .clr(clr), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqData(reqData), .reqReady(reqReady), .respValid(respValid), .respReady(respReady),
    .respData(respData), .respError(respError), .ramWriteEnable(ramWriteEnable),
    .ramReadEnable(ramReadEnable), .ramAddr(ramAddr), .ramReadAddr(ramReadAddr),
    .ramWriteData(ramWriteData), .ramDataReady(ramDataReady), .ramReadData(ramReadData)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] init_pat(input int a);
    return 8'(a * 37 + 90);
  endfunction
  always @(posedge clk) if (ramWriteEnable) begin
    ram[ramAddr] <= ramWriteData;
    written[ramAddr] <= 1'b1;
  end
  assign ramReadData = written[ramReadAddr] ? ram[ramReadAddr] : init_pat(int'(ramReadAddr));
  always @(negedge clk) if (ramWriteEnable && ramReadEnable) excl++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic txn(input bit wr, input logic [7:0] a, input logic [7:0] d, input int dly, input int bp);
    int lat, wcnt, rcnt, eff, e_lat, e_wcnt, e_rcnt;
    logic [7:0] wa, wd, e_wa, e_wd, e_data, hold;
    bit e_err, e_prot;
    e_prot = PROT && wr && (a >= 8'd240);
    eff = dly < 2 ? 2 : dly;
    if (wr) begin
      e_lat = e_prot ? 1 : 2;
      e_err = e_prot;
      e_data = 0;
      e_rcnt = 0;
      if (!e_prot) exp_mem[a] = d;
    end else if (eff <= TMO + 1) begin
      e_lat = eff + 2;
      e_err = 0;
      e_data = exp_mem[a];
      e_rcnt = eff;
    end else begin
      e_lat = TMO + 2;
      e_err = 1;
      e_data = 0;
      e_rcnt = TMO + 1;
    end
    e_wcnt = (wr && !e_prot) ? 1 : 0;
    e_wa = e_wcnt == 1 ? a : 8'd0;
    e_wd = e_wcnt == 1 ? d : 8'd0;
    @(negedge clk);
    reqValid = 1; reqWrite = wr; reqAddr = a; reqData = d; respReady = 0;
    chk("req_ready_idle", reqReady, 1);
    @(posedge clk); #1;
    reqValid = 0;
    lat = -1; wcnt = 0; rcnt = 0; wa = 0; wd = 0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (ramWriteEnable) begin wcnt++; wa = ramAddr; wd = ramWriteData; end
      if (ramReadEnable) rcnt++;
      if (respValid) lat = k;
      ramDataReady = ramReadEnable && (k + 1 >= dly);
    end
    ramDataReady = 0;
    chk("latency", lat, e_lat);
    chk("we_count", wcnt, e_wcnt);
    chk("we_addr", wa, e_wa);
    chk("we_data", wd, e_wd);
    chk("re_cycles", rcnt, e_rcnt);
    chk("resp_data", respData, e_data);
    chk("resp_error", respError, e_err);
    chk("re_low_in_resp", ramReadEnable, 0);
    hold = respData;
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      chk("bp_valid", respValid, 1);
      chk("bp_data", respData, hold);
      chk("bp_req_ready", reqReady, 0);
    end
    respReady = 1;
    @(posedge clk); #1;
    respReady = 0;
    chk("valid_cleared", respValid, 0);
    chk("req_ready_back", reqReady, 1);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_pat(i);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", reqReady, 1);
    chk("rst_resp_valid", respValid, 0);
    chk("rst_we", ramWriteEnable, 0);
    chk("rst_re", ramReadEnable, 0);
    chk("rst_resp_data", respData, 0);
    clr = 1;
    txn(1, 8'd8, 8'h0C, 0, 0);
    txn(1, 8'd5, 8'h5A, 0, 0);
    txn(0, 8'd5, 8'h00, 1, 0);
    txn(0, 8'd8, 8'h00, 3, 0);
    txn(0, 8'd20, 8'h00, 255, 0);
    txn(1, 8'd30, 8'h77, 0, 5);
    txn(0, 8'd30, 8'h00, 1, 5);
    txn(1, 8'd242, 8'hA5, 0, 0);
    txn(0, 8'd242, 8'h00, 2, 0);
    txn(0, 8'd255, 8'h00, 16, 0);
    txn(0, 8'd0, 8'h00, 17, 0);
    txn(1, 8'd0, 8'h3C, 0, 1);
    txn(0, 8'd0, 8'h00, 5, 0);
    // reset in the middle of a load that would otherwise time out
    @(negedge clk);
    reqValid = 1; reqWrite = 0; reqAddr = 8'd9;
    @(posedge clk); #1;
    reqValid = 0;
    repeat (4) @(posedge clk);
    #2 clr = 0;
    #1;
    chk("mid_rst_re", ramReadEnable, 0);
    chk("mid_rst_we", ramWriteEnable, 0);
    chk("mid_rst_valid", respValid, 0);
    chk("mid_rst_req_ready", reqReady, 1);
    @(negedge clk) clr = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_resp", respValid, 0);
    chk("post_rst_re", ramReadEnable, 0);
    txn(0, 8'd9, 8'h00, 1, 0);
    txn(1, 8'd9, 8'hE1, 0, 0);
    txn(0, 8'd9, 8'h00, 2, 0);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
          int'($urandom_range(1, 19)), int'($urandom_range(0, 3)));
    chk("we_re_exclusive", excl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter width, default 8, data word width in bits; SHALL match the downstream data RAM.
REQ-002 Parameter length, default 8, address width in bits; RAM depth is 2**length.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before a read is aborted; range 1..255.
REQ-004 Parameter PROT_BASE, default 240, first write-protected address (interrupt handler region).
REQ-005 Ports, one clock; reset is asynchronous and active-low:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqWrite  in  1  1 = store, 0 = load.
- reqAddr  in  length  request address.
- reqData  in  width  store data.
- reqReady  out  1  controller accepts a request.
- respValid  out  1  response present.
- respReady  in  1  consumer accepts the response.
- respData  out  width  load data; 0 for stores and errors.
- respError  out  1  response flags timeout or protection fault.
- ramWriteEnable  out  1  to RAM writeEnable.
- ramReadEnable  out  1  to RAM readEnable.
- ramAddr  out  length  to RAM write address.
- ramReadAddr  out  length  to RAM read address.
- ramWriteData  out  width  to RAM write data.
- ramDataReady  in  1  from RAM dataReady.
- ramReadData  in  width  from RAM read data.

Function
REQ-006 The FSM SHALL have states IDLE, WRITE, READ, WAIT, CAPT and RESP; all outputs except reqReady SHALL be registered.
REQ-007 reqReady SHALL be 1 in IDLE only; a handshake occurs on a posedge with reqValid=1 and reqReady=1.
REQ-008 On handshake, reqAddr, reqData and reqWrite SHALL be latched; next state is WRITE if reqWrite=1, else READ.
REQ-009 WRITE SHALL drive ramWriteEnable=1, ramAddr=latched address and ramWriteData=latched data for exactly one cycle; it SHALL then go to RESP with respError=0 and respData=0.
REQ-010 READ SHALL assert ramReadEnable=1 with ramReadAddr=latched address, clear the timeout counter, and go to WAIT.
REQ-011 WAIT SHALL hold ramReadEnable=1 and increment an 8-bit counter each cycle.
REQ-012 In WAIT, ramDataReady=1 at a posedge SHALL deassert ramReadEnable and move the FSM to CAPT; this takes priority over a timeout on the same edge.
REQ-013 CAPT SHALL sample ramReadData into respData one cycle after ramDataReady is seen, allowing for RAM output delay; it SHALL then go to RESP with respError=0.
REQ-014 If the counter reaches TIMEOUT in WAIT, ramReadEnable SHALL drop and the FSM SHALL go to RESP with respError=1 and respData=0.
REQ-015 RESP SHALL hold respValid=1 and respData/respError stable until respReady=1; it SHALL then clear respValid and return to IDLE.
REQ-016 ramWriteEnable and ramReadEnable SHALL never be 1 in the same cycle.
REQ-017 Minimum latency from handshake to respValid SHALL be 2 cycles for a store and 4 cycles for a load.
REQ-018 Address wrap-around SHALL NOT occur; every address 0..2**length-1 is passed unmodified.

Reset
REQ-019 While clr=0, state=IDLE, counter=0 and all registered outputs=0 asynchronously; reqReady=1.
REQ-020 Reset mid-operation SHALL drop RAM enables immediately, discard the latched request and produce no response.

Configuration
REQ-021 With macro MEMCTRL_WRITE_PROTECT_EN defined, a store to an address >= PROT_BASE SHALL skip WRITE, never assert ramWriteEnable, and go directly to RESP with respError=1.
REQ-022 Without MEMCTRL_WRITE_PROTECT_EN, all stores SHALL be performed; loads are unaffected in both builds.

Verification
REQ-023 Store: addr 8, data 0x0C, respReady=1 -> one-cycle ramWriteEnable with ramAddr=8; respValid 2 cycles after handshake; respError=0.
REQ-024 Load: RAM returns dataReady 1 cycle after enable with data 0x5A at addr 5 -> respData=0x5A, respError=0, no write enable seen.
REQ-025 Load with ramDataReady held 0 -> respError=1 and respData=0 after TIMEOUT=15 WAIT cycles; ramReadEnable low afterwards.
REQ-026 Backpressure: respReady=0 for 5 cycles -> respValid and respData stable throughout; reqReady=0 until respReady=1 and the FSM returns to IDLE.
REQ-027 Store to addr 242: with MEMCTRL_WRITE_PROTECT_EN -> respError=1 and no ramWriteEnable; without it -> write is performed and respError=0.
REQ-028 Assert clr=0 in WAIT -> ramReadEnable=0 immediately, respValid=0, reqReady=1; the first request after reset completes normally.
